// File: rtl/key_press_decoder.sv
// Turns the debounced, active-low key level into single-cycle press, short-release,
// long-press, auto-repeat and long-release pulses, and keeps an 8-bit wrapping press count.
module key_press_decoder #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       keyin_i,
  output logic       press_o,
  output logic       short_rel_o,
  output logic       long_pulse_o,
  output logic       repeat_pulse_o,
  output logic       long_rel_o,
  output logic       held_o,
  output logic [7:0] press_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_q;
  logic [7:0]       pressCount_q;
  logic             press_q;
  logic             shortRel_q;
  logic             longPulse_q;
  logic             repeatPulse_q;
  logic             longRel_q;
  logic             held_q;

  // key_q clears on reset, so a key already held down needs a release before it counts.
  logic pressEdge;
  assign pressEdge = key_q & ~keyin_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_q         <= 1'b0;
      pressCount_q  <= 8'd0;
      press_q       <= 1'b0;
      shortRel_q    <= 1'b0;
      longPulse_q   <= 1'b0;
      repeatPulse_q <= 1'b0;
      longRel_q     <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      key_q         <= keyin_i;
      press_q       <= 1'b0;
      shortRel_q    <= 1'b0;
      longPulse_q   <= 1'b0;
      repeatPulse_q <= 1'b0;
      longRel_q     <= 1'b0;
      held_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressEdge) begin
            state_q      <= PRESSED;
            press_q      <= 1'b1;
            cnt_q        <= CntOne;
            pressCount_q <= pressCount_q + 8'd1;
            held_q       <= 1'b1;
          end
        end
        // Release is tested first so it always beats a threshold hit on the same edge.
        PRESSED: begin
          if (keyin_i) begin
            state_q    <= IDLE;
            shortRel_q <= 1'b1;
            cnt_q      <= '0;
          end else if (cnt_q == LongLast) begin
            state_q     <= LONG;
            longPulse_q <= 1'b1;
            cnt_q       <= '0;
            held_q      <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + CntOne;
            held_q <= 1'b1;
          end
        end
        LONG: begin
          if (keyin_i) begin
            state_q   <= IDLE;
            longRel_q <= 1'b1;
            cnt_q     <= '0;
          end else if (cnt_q == RepeatLast) begin
            repeatPulse_q <= 1'b1;
            cnt_q         <= '0;
            held_q        <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + CntOne;
            held_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press_o        = press_q;
  assign short_rel_o    = shortRel_q;
  assign long_pulse_o   = longPulse_q;
  assign repeat_pulse_o = repeatPulse_q;
  assign long_rel_o     = longRel_q;
  assign held_o         = held_q;
  assign press_count_o  = pressCount_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Bench for key_press_decoder: a hold-length model compared every cycle, plus
// directed scenarios with hand-computed pulse counts and spacings.
module tb_key_press_decoder;

  localparam int LONG = 10;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyin;
  logic       press, shortRel, longPulse, repeatPulse, longRel, held;
  logic [7:0] pressCount;

  key_press_decoder #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .CNT_W        (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .keyin_i       (keyin),
    .press_o       (press),
    .short_rel_o   (shortRel),
    .long_pulse_o  (longPulse),
    .repeat_pulse_o(repeatPulse),
    .long_rel_o    (longRel),
    .held_o        (held),
    .press_count_o (pressCount)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model tracks how many consecutive low samples the current press has lasted.
  bit mPrevKey = 1'b0;
  bit mPressing = 1'b0;
  int mLen = 0;
  int mCount = 0;
  bit ePress, eShort, eLong, eRepeat, eLongRel, eHeld;

  always @(posedge clk) begin
    ePress = 0; eShort = 0; eLong = 0; eRepeat = 0; eLongRel = 0;
    if (rst) begin
      mPrevKey = 0; mPressing = 0; mLen = 0; mCount = 0;
    end else begin
      if (!mPressing) begin
        if (mPrevKey && !keyin) begin
          ePress = 1; mPressing = 1; mLen = 1; mCount = (mCount + 1) % 256;
        end
      end else if (keyin) begin
        if (mLen >= LONG) eLongRel = 1;
        else eShort = 1;
        mPressing = 0;
      end else begin
        mLen++;
        if (mLen == LONG) eLong = 1;
        else if (mLen > LONG && (mLen - LONG) % REP == 0) eRepeat = 1;
      end
      mPrevKey = keyin;
    end
    eHeld = mPressing;
  end

  int cycleNo = 0;
  int pressSeen, shortSeen, longSeen, repeatSeen, longRelSeen, heldCycles;
  int pressCyc, longCyc, firstRepCyc, lastRepCyc;

  always @(negedge clk) begin
    cycleNo++;
    if (checkEn) begin
      checkOutput("press", press, ePress);
      checkOutput("short_rel", shortRel, eShort);
      checkOutput("long_pulse", longPulse, eLong);
      checkOutput("repeat_pulse", repeatPulse, eRepeat);
      checkOutput("long_rel", longRel, eLongRel);
      checkOutput("held", held, eHeld);
      checkOutput("press_count", pressCount, mCount[7:0]);
      checkOutput("one_pulse_max",
                  ((32'(press) + 32'(shortRel) + 32'(longPulse) + 32'(repeatPulse) + 32'(longRel)) > 1) ? 1 : 0, 0);
      if (press === 1'b1) begin pressSeen++; pressCyc = cycleNo; end
      if (shortRel === 1'b1) shortSeen++;
      if (longPulse === 1'b1) begin longSeen++; longCyc = cycleNo; end
      if (repeatPulse === 1'b1) begin
        if (repeatSeen == 0) firstRepCyc = cycleNo;
        repeatSeen++;
        lastRepCyc = cycleNo;
      end
      if (longRel === 1'b1) longRelSeen++;
      if (held === 1'b1) heldCycles++;
    end
  end

  // Drives one sample per cycle, changing inputs 1 time unit after the rising edge.
  task automatic applyStimulus(input logic k, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      keyin = k;
      rst = r;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearObs();
    pressSeen = 0; shortSeen = 0; longSeen = 0; repeatSeen = 0; longRelSeen = 0;
    heldCycles = 0; pressCyc = 0; longCyc = 0; firstRepCyc = 0; lastRepCyc = 0;
  endtask

  initial begin
    keyin = 1'b1;
    rst = 1'b1;
    clearObs();
    applyStimulus(1, 1, 2);
    checkEn = 1'b1;
    checkOutput("reset_press_count", pressCount, 0);
    checkOutput("reset_held", held, 0);

    // Short press: 5 low samples.
    clearObs();
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 5);
    applyStimulus(1, 0, 3);
    checkOutput("short_presses", pressSeen, 1);
    checkOutput("short_rels", shortSeen, 1);
    checkOutput("short_longs", longSeen, 0);
    checkOutput("short_held_cycles", heldCycles, 5);
    checkOutput("short_count", pressCount, 1);
    checkOutput("model_count", mCount, 1);

    // Nine low samples sits just under the long threshold.
    clearObs();
    applyStimulus(0, 0, 9);
    applyStimulus(1, 0, 3);
    checkOutput("race9_short", shortSeen, 1);
    checkOutput("race9_long", longSeen, 0);

    // Ten low samples reaches it; long_pulse trails press by LONG-1 cycles.
    clearObs();
    applyStimulus(0, 0, 10);
    applyStimulus(1, 0, 3);
    checkOutput("race10_long", longSeen, 1);
    checkOutput("race10_longrel", longRelSeen, 1);
    checkOutput("race10_short", shortSeen, 0);
    checkOutput("race10_spacing", longCyc - pressCyc, LONG - 1);

    // 22 low samples: long at sample 10, repeats at samples 14, 18, 22.
    clearObs();
    applyStimulus(0, 0, 22);
    applyStimulus(1, 0, 3);
    checkOutput("rep_long", longSeen, 1);
    checkOutput("rep_count", repeatSeen, 3);
    checkOutput("rep_first", firstRepCyc - longCyc, 4);
    checkOutput("rep_last", lastRepCyc - longCyc, 12);
    checkOutput("rep_longrel", longRelSeen, 1);
    checkOutput("rep_short", shortSeen, 0);

    // Reset partway through a press, key kept low across it.
    clearObs();
    applyStimulus(0, 0, 5);
    applyStimulus(0, 1, 1);
    checkOutput("midrst_held", held, 0);
    checkOutput("midrst_count", pressCount, 0);
    checkOutput("midrst_press", press, 0);
    applyStimulus(0, 0, 5);
    checkOutput("midrst_no_press", pressSeen, 1);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 3);
    applyStimulus(1, 0, 3);
    checkOutput("midrst_repress", pressSeen, 2);
    checkOutput("midrst_count2", pressCount, 1);

    // 256 short presses bring the counter back round to zero.
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 1);
    clearObs();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 0, 3);
      applyStimulus(1, 0, 2);
    end
    checkOutput("wrap_presses", pressSeen, 256);
    checkOutput("wrap_shorts", shortSeen, 256);
    checkOutput("wrap_count", pressCount, 0);

    // Random key stream with occasional reset; the per-cycle compare does the work.
    for (int i = 0; i < 5000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0), 1);
    end
    // Long random runs so the long/repeat paths are exercised too.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 0, 1 + $urandom_range(0, 2));
      applyStimulus(0, 0, 1 + $urandom_range(0, 30));
    end
    applyStimulus(1, 0, 3);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
